// File: rtl/cmp_pkg.sv
// Shared types for the sequential branch comparator.
//   cond_e  : branch condition, encoded as RISC-V funct3
//   state_e : control FSM states
package cmp_pkg;

  typedef enum logic [2:0] {
    COND_EQ  = 3'b000,
    COND_NE  = 3'b001,
    COND_LT  = 3'b100,
    COND_GE  = 3'b101,
    COND_LTU = 3'b110,
    COND_GEU = 3'b111
  } cond_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  // funct3 010/011 are not branch encodings
  function automatic logic cond_is_legal(input logic [2:0] f3);
    return f3[2] | ~f3[1];
  endfunction

endpackage

// File: rtl/chunk_cmp.sv
// Combinational CHUNK-bit unsigned compare of one operand slice.
//   a, b : operand slices
//   diff : a != b
//   lt   : a <  b (unsigned)
module chunk_cmp #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             diff,
  output logic             lt
);

  assign diff = (a != b);
  assign lt   = (a < b);

endmodule

// File: rtl/branch_cmp_seq.sv
// Multi-cycle branch comparator: scans operands CHUNK bits per cycle, MSB
// chunk first, and reports taken plus raw ne/ge/geu flags.
// Optional macro BRCMP_EARLY_EXIT_EN: leave the scan as soon as the first
// differing chunk has decided both the signed and unsigned result.
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid/in_ready    : request handshake (in_ready high only when idle)
//   op_a, op_b, cond     : operands and funct3 branch condition
//   out_valid/out_ready  : result handshake, result held until accepted
//   taken, ne, ge, geu   : branch outcome and raw compare flags
//   illegal              : cond was 010 or 011
module branch_cmp_seq
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [2:0]       cond,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             taken,
  output logic             ne,
  output logic             ge,
  output logic             geu,
  output logic             illegal
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0]  IDX_TOP  = IDXW'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

  if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("branch_cmp_seq: WIDTH must be a multiple of CHUNK");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]       cond_q, cond_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             dec_u_q, dec_u_d, lt_u_q, lt_u_d;
  logic             dec_s_q, dec_s_d, lt_s_q, lt_s_d;
  logic             differ_q, differ_d;
  logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic             taken_q, taken_d, ne_q, ne_d, ge_q, ge_d;
  logic             geu_q, geu_d, illegal_q, illegal_d;

  // Current chunk of the raw operands and of the sign-flipped copies
  logic [WIDTH-1:0] a_shift, b_shift, as_shift, bs_shift;
  logic [CHUNK-1:0] a_chunk, b_chunk, as_chunk, bs_chunk;
  logic             u_diff, u_lt, s_diff, s_lt;

  assign a_shift  = a_q >> (32'(idx_q) * CHUNK);
  assign b_shift  = b_q >> (32'(idx_q) * CHUNK);
  assign as_shift = (a_q ^ MSB_MASK) >> (32'(idx_q) * CHUNK);
  assign bs_shift = (b_q ^ MSB_MASK) >> (32'(idx_q) * CHUNK);
  assign a_chunk  = a_shift[CHUNK-1:0];
  assign b_chunk  = b_shift[CHUNK-1:0];
  assign as_chunk = as_shift[CHUNK-1:0];
  assign bs_chunk = bs_shift[CHUNK-1:0];

  chunk_cmp #(.CHUNK(CHUNK)) u_cmp_u (
    .a    (a_chunk),
    .b    (b_chunk),
    .diff (u_diff),
    .lt   (u_lt)
  );

  chunk_cmp #(.CHUNK(CHUNK)) u_cmp_s (
    .a    (as_chunk),
    .b    (bs_chunk),
    .diff (s_diff),
    .lt   (s_lt)
  );

  // Scan results including the current chunk
  logic lt_u_n, dec_u_n, lt_s_n, dec_s_n, differ_n, last_chunk;

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    cond_d      = cond_q;
    idx_d       = idx_q;
    dec_u_d     = dec_u_q;
    lt_u_d      = lt_u_q;
    dec_s_d     = dec_s_q;
    lt_s_d      = lt_s_q;
    differ_d    = differ_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    taken_d     = taken_q;
    ne_d        = ne_q;
    ge_d        = ge_q;
    geu_d       = geu_q;
    illegal_d   = illegal_q;

    // The first differing chunk decides; later chunks cannot change it
    lt_u_n   = dec_u_q ? lt_u_q : (u_diff & u_lt);
    dec_u_n  = dec_u_q | u_diff;
    lt_s_n   = dec_s_q ? lt_s_q : (s_diff & s_lt);
    dec_s_n  = dec_s_q | s_diff;
    differ_n = differ_q | u_diff;
`ifdef BRCMP_EARLY_EXIT_EN
    last_chunk = (idx_q == '0) | (dec_u_n & dec_s_n);
`else
    last_chunk = (idx_q == '0);
`endif

    unique case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d        = op_a;
          b_d        = op_b;
          cond_d     = cond;
          idx_d      = IDX_TOP;
          dec_u_d    = 1'b0;
          lt_u_d     = 1'b0;
          dec_s_d    = 1'b0;
          lt_s_d     = 1'b0;
          differ_d   = 1'b0;
          in_ready_d = 1'b0;
          state_d    = S_BUSY;
        end
      end
      S_BUSY: begin
        lt_u_d   = lt_u_n;
        dec_u_d  = dec_u_n;
        lt_s_d   = lt_s_n;
        dec_s_d  = dec_s_n;
        differ_d = differ_n;
        idx_d    = idx_q - IDXW'(1);
        if (last_chunk) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          ne_d        = differ_n;
          ge_d        = ~lt_s_n;
          geu_d       = ~lt_u_n;
          illegal_d   = ~cond_is_legal(cond_q);
          case (cond_e'(cond_q))
            COND_EQ:  taken_d = ~differ_n;
            COND_NE:  taken_d = differ_n;
            COND_LT:  taken_d = lt_s_n;
            COND_GE:  taken_d = ~lt_s_n;
            COND_LTU: taken_d = lt_u_n;
            COND_GEU: taken_d = ~lt_u_n;
            default:  taken_d = 1'b0;
          endcase
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      cond_q      <= '0;
      idx_q       <= '0;
      dec_u_q     <= 1'b0;
      lt_u_q      <= 1'b0;
      dec_s_q     <= 1'b0;
      lt_s_q      <= 1'b0;
      differ_q    <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      taken_q     <= 1'b0;
      ne_q        <= 1'b0;
      ge_q        <= 1'b0;
      geu_q       <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cond_q      <= cond_d;
      idx_q       <= idx_d;
      dec_u_q     <= dec_u_d;
      lt_u_q      <= lt_u_d;
      dec_s_q     <= dec_s_d;
      lt_s_q      <= lt_s_d;
      differ_q    <= differ_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      taken_q     <= taken_d;
      ne_q        <= ne_d;
      ge_q        <= ge_d;
      geu_q       <= geu_d;
      illegal_q   <= illegal_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign taken     = taken_q;
  assign ne        = ne_q;
  assign ge        = ge_q;
  assign geu       = geu_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_branch_cmp_seq.sv
// Self-checking bench for branch_cmp_seq: a cycle-level reference model
// checked every cycle, plus directed operations with literal expectations.
module tb_branch_cmp_seq;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned CHUNK  = 8;
  localparam int unsigned NCHUNK = WIDTH / CHUNK;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [2:0]       cond;
  logic             out_valid;
  logic             out_ready;
  logic             taken;
  logic             ne;
  logic             ge;
  logic             geu;
  logic             illegal;

  branch_cmp_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .cond      (cond),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .taken     (taken),
    .ne        (ne),
    .ge        (ge),
    .geu       (geu),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result: {taken, ne, ge, geu, illegal}
  function automatic logic [4:0] ref_result(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic [2:0] c);
    logic r_ne, r_ge, r_geu, r_taken, r_ill;
    r_ne    = (a != b);
    r_ge    = ($signed(a) >= $signed(b));
    r_geu   = (a >= b);
    r_ill   = (c == 3'b010) || (c == 3'b011);
    case (c)
      3'b000:  r_taken = !r_ne;
      3'b001:  r_taken = r_ne;
      3'b100:  r_taken = !r_ge;
      3'b101:  r_taken = r_ge;
      3'b110:  r_taken = !r_geu;
      3'b111:  r_taken = r_geu;
      default: r_taken = 1'b0;
    endcase
    return {r_taken, r_ne, r_ge, r_geu, r_ill};
  endfunction

  // Reference latency in cycles from the accept edge to out_valid
  function automatic int ref_latency(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int lat;
    lat = NCHUNK;
`ifdef BRCMP_EARLY_EXIT_EN
    for (int i = NCHUNK - 1; i >= 0; i--) begin
      if (((a >> (i * CHUNK)) & ((1 << CHUNK) - 1)) != ((b >> (i * CHUNK)) & ((1 << CHUNK) - 1))) begin
        lat = NCHUNK - i;
        break;
      end
    end
`endif
    return lat;
  endfunction

  // Cycle-level model: idle / counting down / holding a result
  logic       m_armed = 1'b0;
  logic       m_idle  = 1'b1;
  logic       m_ov    = 1'b0;
  logic       m_fresh = 1'b0;
  int         m_rem   = 0;
  logic [4:0] m_res   = '0;
  logic [4:0] m_flags = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_armed = 1'b1;
      m_idle  = 1'b1;
      m_ov    = 1'b0;
      m_fresh = 1'b1;
      m_flags = '0;
    end else if (m_idle) begin
      if (in_valid) begin
        m_idle = 1'b0;
        m_rem  = ref_latency(op_a, op_b);
        m_res  = ref_result(op_a, op_b, cond);
      end
    end else if (!m_ov) begin
      m_rem--;
      if (m_rem == 0) begin
        m_ov    = 1'b1;
        m_fresh = 1'b0;
        m_flags = m_res;
      end
    end else if (out_ready) begin
      m_ov   = 1'b0;
      m_idle = 1'b1;
    end
    #1;
    if (m_armed) begin
      chk("model_in_ready", 32'(in_ready), 32'(m_idle));
      chk("model_out_valid", 32'(out_valid), 32'(m_ov));
      if (m_ov || m_fresh)
        chk("model_flags", 32'({taken, ne, ge, geu, illegal}), 32'(m_flags));
    end
  end

  // One operation; caller sits 1 time unit after a rising edge with the DUT idle
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [2:0] c, input int hold,
                        input logic exp_taken, input logic exp_ill, input int exp_lat);
    int k;
    in_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    cond     = c;
    @(posedge clk); #1;
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    chk("latency", 32'(k), 32'(exp_lat));
    chk("taken", 32'(taken), 32'(exp_taken));
    chk("illegal", 32'(illegal), 32'(exp_ill));
    for (int h = 0; h < hold; h++) begin
      // A competing request while busy must be dropped
      in_valid = 1'b1;
      op_a     = ~a;
      op_b     = b;
      cond     = 3'b001;
      @(posedge clk); #1;
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_taken", 32'(taken), 32'(exp_taken));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("after_ack_in_ready", 32'(in_ready), 32'd1);
    chk("after_ack_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    logic [2:0]       rc;
    logic [4:0]       rr;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_a      = '0;
    op_b      = '0;
    cond      = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_flags", 32'({taken, ne, ge, geu, illegal}), 32'd0);

    // Equal operands: full scan in every build
    run_op(32'd5, 32'd5, 3'b000, 0, 1'b1, 1'b0, 4);
    chk("eq_flags", 32'({ne, ge, geu}), 32'b011);

`ifdef BRCMP_EARLY_EXIT_EN
    run_op(32'hFFFF_FFFF, 32'd1, 3'b100, 0, 1'b1, 1'b0, 1);
    chk("lt_flags", 32'({ne, ge, geu}), 32'b101);
    run_op(32'hFFFF_FFFF, 32'd1, 3'b110, 0, 1'b0, 1'b0, 1);
    run_op(32'h8000_0000, 32'h7FFF_FFFF, 3'b101, 0, 1'b0, 1'b0, 1);
    run_op(32'h8000_0000, 32'h7FFF_FFFF, 3'b111, 0, 1'b1, 1'b0, 1);
    run_op(32'h0000_0100, 32'h0000_0001, 3'b001, 0, 1'b1, 1'b0, 3);
`else
    run_op(32'hFFFF_FFFF, 32'd1, 3'b100, 0, 1'b1, 1'b0, 4);
    chk("lt_flags", 32'({ne, ge, geu}), 32'b101);
    run_op(32'hFFFF_FFFF, 32'd1, 3'b110, 0, 1'b0, 1'b0, 4);
    run_op(32'h8000_0000, 32'h7FFF_FFFF, 3'b101, 0, 1'b0, 1'b0, 4);
    run_op(32'h8000_0000, 32'h7FFF_FFFF, 3'b111, 0, 1'b1, 1'b0, 4);
    run_op(32'h0000_0100, 32'h0000_0001, 3'b001, 0, 1'b1, 1'b0, 4);
`endif

    // Back-pressure for 5 cycles with a competing request
    run_op(32'h1234_5678, 32'h1234_5678, 3'b001, 5, 1'b0, 1'b0, 4);

    // Reset in the middle of a scan
    in_valid = 1'b1;
    op_a     = 32'h0000_0100;
    op_b     = 32'h0000_0001;
    cond     = 3'b001;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_flags", 32'({taken, ne, ge, geu, illegal}), 32'd0);

    // Illegal condition: flags still computed, taken forced low
    run_op(32'd5, 32'd9, 3'b010, 0, 1'b0, 1'b1, 4);
    chk("illegal_flags", 32'({ne, ge, geu}), 32'b100);
    run_op(32'hFFFF_FF00, 32'hFFFF_FF00, 3'b011, 0, 1'b0, 1'b1, 4);

    // Extra vectors checked against the reference functions
    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = (i % 2 == 0) ? ((ra & 32'hFFFF_0000) | (32'($urandom) & 32'h0000_FFFF)) : 32'($urandom);
      case (i % 6)
        0: rc = 3'b000;
        1: rc = 3'b001;
        2: rc = 3'b100;
        3: rc = 3'b101;
        4: rc = 3'b110;
        default: rc = 3'b111;
      endcase
      rr = ref_result(ra, rb, rc);
      run_op(ra, rb, rc, i % 3, rr[4], rr[0], ref_latency(ra, rb));
      chk("rand_flags", 32'({ne, ge, geu}), 32'(rr[3:1]));
    end

    repeat (2) @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
